// File: rtl/uart6551_baud_gen.sv
// Baud tick generator for the 6551-compatible UART.
// Turns the baud LUT divisor into a one-clock 16x-oversample strobe. It also
// derives the transmit bit-boundary strobe and the receive mid-bit sample strobe.
// A divisor of 0 selects external 16x clock mode, where xclk_i is synchronised
// and its rising edges become the 16x strobe.
module uart6551_baud_gen #(
  parameter int unsigned pCounterBits = 24,
  parameter int unsigned pSyncStages  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [pCounterBits-1:0] div_i,
  input  logic                    xclk_i,
  input  logic                    rxstart_i,
  output logic                    baud16_o,
  output logic                    txbit_o,
  output logic                    rxsample_o,
  output logic                    ext_mode_o,
  output logic                    div_chg_o
);

  localparam logic [pCounterBits-1:0] CntOne = pCounterBits'(1);

  logic [pCounterBits-1:0] div_q;
  logic [pCounterBits-1:0] cnt;
  logic [3:0]              tx_ph;
  logic [3:0]              rx_ph;
  logic [pSyncStages-1:0]  sync_q;
  logic                    xclk_prev;

  logic                    div_mismatch;
  logic                    ext_mode;
  logic [pCounterBits-1:0] reload;
  logic [pCounterBits-1:0] load_val;
  logic                    ext_edge;
  logic                    tick;

  assign div_mismatch = (div_i != div_q);
  assign ext_mode     = (div_q == '0);

  // NOTE: guard the decrement so a zero divisor never wraps to all-ones;
  // in external mode the counter simply parks at 0.
  assign reload   = ext_mode ? '0 : (div_q - CntOne);
  assign load_val = (div_i == '0) ? '0 : (div_i - CntOne);

  assign ext_edge = sync_q[pSyncStages-1] & ~xclk_prev;

  // A new divisor always suppresses the strobe in the cycle it is latched.
  assign tick = en_i & ~div_mismatch & (ext_mode ? ext_edge : (cnt == '0));

  // External clock synchroniser and rising-edge history; runs in every mode.
  // NOTE: all state below is updated with non-blocking assignments, so each
  // register samples the pre-edge value of the others regardless of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      xclk_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[pSyncStages-2:0], xclk_i};
      xclk_prev <= sync_q[pSyncStages-1];
    end
  end

  // Divisor latch and 16x down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (div_mismatch) begin
      div_q <= div_i;
      cnt   <= load_val;
    end else if (!en_i || ext_mode || (cnt == '0)) begin
      cnt   <= reload;
    end else begin
      cnt   <= cnt - CntOne;
    end
  end

  // Transmit and receive bit phase within the 16 oversample ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ph <= 4'd0;
      rx_ph <= 4'd0;
    end else if (div_mismatch || !en_i) begin
      tx_ph <= 4'd0;
      rx_ph <= 4'd0;
    end else begin
      if (tick) begin
        tx_ph <= tx_ph + 4'd1;
      end
      // A start-bit edge realigns the receive phase even on a tick cycle.
      if (rxstart_i) begin
        rx_ph <= 4'd0;
      end else if (tick) begin
        rx_ph <= rx_ph + 4'd1;
      end
    end
  end

  // Registered strobes and status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud16_o   <= 1'b0;
      txbit_o    <= 1'b0;
      rxsample_o <= 1'b0;
      ext_mode_o <= 1'b0;
      div_chg_o  <= 1'b0;
    end else begin
      baud16_o   <= tick;
      txbit_o    <= tick & (tx_ph == 4'd15);
      rxsample_o <= tick & ~rxstart_i & (rx_ph == 4'd7);
      div_chg_o  <= div_mismatch;
      ext_mode_o <= div_mismatch ? (div_i == '0) : ext_mode;
    end
  end

endmodule

// File: tb/tb_uart6551_baud_gen.sv
// Self-checking bench for uart6551_baud_gen.
// A cycle-level model predicts every output from elapsed clocks, tick counts
// and the sampled external clock history; directed scenarios add literal timing checks.
module tb_uart6551_baud_gen;

  localparam int CntBits = 24;
  localparam int Sync    = 2;

  localparam int SelBaud = 0;
  localparam int SelTx   = 1;
  localparam int SelRx   = 2;
  localparam int SelChg  = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               en_i = 1'b0;
  logic [CntBits-1:0] div_i = '0;
  logic               xclk_i = 1'b0;
  logic               rxstart_i = 1'b0;
  logic               baud16_o;
  logic               txbit_o;
  logic               rxsample_o;
  logic               ext_mode_o;
  logic               div_chg_o;

  int n_checks = 0;
  int n_errors = 0;

  uart6551_baud_gen #(
    .pCounterBits(CntBits),
    .pSyncStages (Sync)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .div_i     (div_i),
    .xclk_i    (xclk_i),
    .rxstart_i (rxstart_i),
    .baud16_o  (baud16_o),
    .txbit_o   (txbit_o),
    .rxsample_o(rxsample_o),
    .ext_mode_o(ext_mode_o),
    .div_chg_o (div_chg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ticks happen when the clocks elapsed since the last load/disable are a
  // multiple of the divisor, or S samples after a sampled rising xclk edge.
  int         m_div = 0;
  int         m_since = 0;
  int         m_ticks = 0;
  int         m_rxticks = 0;
  logic [7:0] m_hist = '0;
  logic       m_tick = 1'b0;
  logic       e_baud = 1'b0;
  logic       e_tx = 1'b0;
  logic       e_rx = 1'b0;
  logic       e_ext = 1'b0;
  logic       e_chg = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_div = 0; m_since = 0; m_ticks = 0; m_rxticks = 0; m_hist = '0;
        e_baud = 0; e_tx = 0; e_rx = 0; e_ext = 0; e_chg = 0;
      end else begin
        m_hist = {m_hist[6:0], xclk_i};
        e_baud = 0; e_tx = 0; e_rx = 0; e_chg = 0; m_tick = 0;
        if (int'(div_i) != m_div) begin
          m_div = int'(div_i);
          m_since = 0; m_ticks = 0; m_rxticks = 0;
          e_chg = 1;
          e_ext = (m_div == 0);
        end else begin
          e_ext = (m_div == 0);
          if (!en_i) begin
            m_since = 0; m_ticks = 0; m_rxticks = 0;
          end else begin
            if (m_div == 0) begin
              m_tick = m_hist[Sync] && !m_hist[Sync+1];
            end else begin
              m_since++;
              m_tick = ((m_since % m_div) == 0);
            end
            if (m_tick) begin
              m_ticks++;
              e_baud = 1;
              e_tx = ((m_ticks % 16) == 0);
            end
            if (rxstart_i) begin
              m_rxticks = 0;
            end else if (m_tick) begin
              m_rxticks++;
              e_rx = ((m_rxticks % 16) == 8);
            end
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      check("cyc_baud16",   32'(baud16_o),   32'(e_baud));
      check("cyc_txbit",    32'(txbit_o),    32'(e_tx));
      check("cyc_rxsample", 32'(rxsample_o), 32'(e_rx));
      check("cyc_ext_mode", 32'(ext_mode_o), 32'(e_ext));
      check("cyc_div_chg",  32'(div_chg_o),  32'(e_chg));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      SelBaud: return baud16_o;
      SelTx:   return txbit_o;
      SelRx:   return rxsample_o;
      default: return div_chg_o;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  // Clocks until the selected output is seen high; -1 if the budget expires.
  task automatic measure(input int sel, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk_i);
      #2;
      if (sig(sel) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c_baud, c_tx, c_rx;

    // Reset state
    wait_cyc(3);
    check("reset_outputs", 32'({baud16_o, txbit_o, rxsample_o, ext_mode_o, div_chg_o}), 32'd0);
    rst_ni = 1'b1;
    wait_cyc(2);
    check("ext_after_reset", 32'(ext_mode_o), 32'd1);

    // 1: divisor 326
    div_i = 24'd326; en_i = 1'b1;
    measure(SelChg, 10, n);     check("t1_chg_latency", n, 1);
    check("t1_ext_mode", 32'(ext_mode_o), 32'd0);
    measure(SelBaud, 1000, n);  check("t1_first_baud", n, 326);
    measure(SelBaud, 1000, n);  check("t1_baud_period", n, 326);
    measure(SelTx, 6000, n);    check("t1_txbit_at_5216", n, 5216 - 652);

    // 2: divisor 1
    div_i = 24'd1;
    measure(SelChg, 10, n);     check("t2_chg_latency", n, 1);
    c_baud = 0; c_tx = 0; c_rx = 0;
    for (int i = 0; i < 64; i++) begin
      wait_cyc(1);
      c_baud += int'(baud16_o); c_tx += int'(txbit_o); c_rx += int'(rxsample_o);
    end
    check("t2_baud_count", c_baud, 64);
    check("t2_tx_count", c_tx, 4);
    check("t2_rx_count", c_rx, 4);

    // 3: divisor change mid-count
    div_i = 24'd651;
    measure(SelChg, 10, n);     check("t3_chg_651", n, 1);
    wait_cyc(300);
    div_i = 24'd326;
    measure(SelChg, 10, n);     check("t3_chg_326", n, 1);
    measure(SelBaud, 1000, n);  check("t3_first_baud", n, 326);
    measure(SelTx, 6000, n);    check("t3_tx_restart", n, 15 * 326);

    // Enable gating in internal mode
    div_i = 24'd10;
    measure(SelChg, 10, n);     check("en_chg", n, 1);
    en_i = 1'b0;
    wait_cyc(30);
    en_i = 1'b1;
    measure(SelBaud, 100, n);   check("en_first_baud", n, 10);

    // 4: external clock mode, xclk period 10 clocks
    div_i = '0; xclk_i = 1'b0;
    measure(SelChg, 10, n);     check("t4_chg", n, 1);
    check("t4_ext_mode", 32'(ext_mode_o), 32'd1);
    wait_cyc(5);
    for (int i = 0; i < 4; i++) begin
      xclk_i = 1'b1;
      measure(SelBaud, 10, n);  check("t4_ext_latency", n, Sync + 1);
      wait_cyc(2);
      xclk_i = 1'b0;
      wait_cyc(5);
    end
    en_i = 1'b0;
    c_baud = 0;
    for (int i = 0; i < 30; i++) begin
      xclk_i = ((i % 10) < 5);
      wait_cyc(1);
      c_baud += int'(baud16_o);
    end
    check("t4_disabled_count", c_baud, 0);
    xclk_i = 1'b0;
    en_i = 1'b1;
    wait_cyc(5);

    // 5: receive sampling at divisor 163
    div_i = 24'd163;
    measure(SelChg, 10, n);     check("t5_chg", n, 1);
    measure(SelBaud, 1000, n);  check("t5_first_baud", n, 163);
    rxstart_i = 1'b1;
    wait_cyc(1);
    rxstart_i = 1'b0;
    measure(SelRx, 3000, n);    check("t5_rx_centre", n, 8 * 163 - 1);
    measure(SelRx, 3000, n);    check("t5_rx_period", n, 16 * 163);
    wait_cyc(162);
    rxstart_i = 1'b1;           // sampled on the next tick edge
    wait_cyc(1);
    check("t5_coincident_nosample", 32'(rxsample_o), 32'd0);
    rxstart_i = 1'b0;
    measure(SelRx, 3000, n);    check("t5_coincident_realign", n, 8 * 163);

    // 6: reset while a strobe is high
    div_i = 24'd326;
    measure(SelChg, 10, n);     check("t6_chg", n, 1);
    measure(SelBaud, 1000, n);  check("t6_baud", n, 326);
    rst_ni = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({baud16_o, txbit_o, rxsample_o, ext_mode_o, div_chg_o}), 32'd0);
    wait_cyc(2);
    rst_ni = 1'b1;
    measure(SelChg, 10, n);     check("t6_reload_chg", n, 1);
    measure(SelBaud, 1000, n);  check("t6_restart_baud", n, 326);

    wait_cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
